// File: rtl/sparc_mem_pkg.sv
// Shared encodings and helpers for the SPARC MAR/MDR memory controller.
package sparc_mem_pkg;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_WORD = 2'b10;
  localparam logic [1:0] TYPE_RSVD = 2'b11;

  // State names carry a prefix so they cannot collide with the WAIT parameter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the access size and low address bits do not line up.
  function automatic logic misaligned(input logic [1:0] typ, input logic [1:0] off);
    logic r;
    case (typ)
      TYPE_BYTE: r = 1'b0;
      TYPE_HALF: r = off[0];
      TYPE_WORD: r = (off != 2'b00);
      default:   r = 1'b1;
    endcase
    return r;
  endfunction

  // Lane-enable mask; bit k selects lane k, where lane 0 is the most significant byte.
  function automatic logic [3:0] be_lanes(input logic [1:0] typ, input logic [1:0] off);
    logic [3:0] r;
    case (typ)
      TYPE_BYTE: r = 4'b0001 << off;
      TYPE_HALF: r = 4'b0011 << off;
      TYPE_WORD: r = 4'b1111;
      default:   r = 4'b0000;
    endcase
    return r;
  endfunction

  // Pull the addressed byte/halfword out of a big-endian word and extend it.
  function automatic logic [31:0] be_extract(input logic [31:0] word, input logic [1:0] typ,
                                             input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (typ)
      TYPE_BYTE: r = {{24{sgn & b[7]}}, b};
      TYPE_HALF: r = {{16{sgn & h[15]}}, h};
      TYPE_WORD: r = word;
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sparc_byte_ram.sv
// DEPTH x 8 byte RAM: four-lane aligned word port plus a single-byte preload port.
module sparc_byte_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [3:0]        we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        ld_data_i
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] lane_addr_s [4];

  // Byte addresses of the four lanes of the aligned word containing base_i.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr_s[k] = (base_i & ~ADDR_W'(3)) | ADDR_W'(k);
    end
  end

  // Asynchronous big-endian read of the whole aligned word.
  always_comb begin
    rdata_o = {mem_q[lane_addr_s[0]], mem_q[lane_addr_s[1]],
               mem_q[lane_addr_s[2]], mem_q[lane_addr_s[3]]};
  end

  // Array writes; never reset. Preload and lane writes are mutually exclusive upstream.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem_q[lane_addr_s[k]] <= wdata_i[31-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/sparc_mem_ctrl.sv
// Big-endian memory with MOV/MOC four-phase handshake, programmable wait states,
// signed sub-word loads, alignment-error reporting and a preload port.
module sparc_mem_ctrl
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int WAIT   = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Type,
  input  logic              Sign,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Align_Err,
  input  logic              Ld_En,
  input  logic [ADDR_W-1:0] Ld_Addr,
  input  logic [7:0]        Ld_Data
);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        type_q;
  logic              rw_q;
  logic              sign_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic              moc_q;
  logic              err_q;

  logic [1:0]  off_s;
  logic        err_s;
  logic        complete_s;
  logic [3:0]  we_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  logic        ld_we_s;

  // Decode of the captured access: error flag, commit strobe, lane enables and data.
  always_comb begin
    off_s      = addr_q[1:0];
    err_s      = misaligned(type_q, off_s);
    complete_s = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    if (complete_s && !rw_q && !err_s) begin
      we_s = be_lanes(type_q, off_s);
    end else begin
      we_s = 4'b0000;
    end
    case (type_q)
      TYPE_BYTE: wdata_s = {4{din_q[7:0]}};
      TYPE_HALF: wdata_s = {2{din_q[15:0]}};
      default:   wdata_s = din_q;
    endcase
    // MOV has priority: a preload is only honoured in an idle cycle with no request.
    ld_we_s = Ld_En && (state_q == ST_IDLE) && !MOV;
  end

  sparc_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i     (Clk),
    .base_i    (addr_q),
    .we_i      (we_s),
    .wdata_i   (wdata_s),
    .rdata_o   (rdata_s),
    .ld_we_i   (ld_we_s),
    .ld_addr_i (Ld_Addr),
    .ld_data_i (Ld_Data)
  );

  // Handshake FSM with wait counter, request capture and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      type_q  <= TYPE_BYTE;
      rw_q    <= 1'b0;
      sign_q  <= 1'b0;
      din_q   <= 32'h0000_0000;
      dout_q  <= 32'h0000_0000;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MOV) begin
            addr_q  <= Address;
            type_q  <= Type;
            rw_q    <= RW;
            sign_q  <= Sign;
            din_q   <= DataIn;
            cnt_q   <= 4'(WAIT);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            moc_q   <= 1'b1;
            err_q   <= err_s;
            state_q <= ST_DONE;
            // Faulting accesses leave DataOut untouched.
            if (rw_q && !err_s) begin
              dout_q <= be_extract(rdata_s, type_q, off_s, sign_q);
            end
          end
        end
        ST_DONE: begin
          if (!MOV) begin
            moc_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          moc_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign DataOut   = dout_q;
  assign MOC       = moc_q;
  assign Align_Err = err_q;

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Randomised self-checking bench: two controllers (WAIT=2 and WAIT=3) share the
// same stimulus and are compared against a byte-array reference model.
module tb_sparc_mem_ctrl;

  localparam int AW = 9;
  localparam int DEPTH = 2 ** AW;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          MOV, RW, Sign, Ld_En;
  logic [1:0]    Type;
  logic [AW-1:0] Address, Ld_Addr;
  logic [31:0]   DataIn;
  logic [7:0]    Ld_Data;

  logic [31:0] dout_a, dout_b;
  logic        moc_a, moc_b, err_a, err_b;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  mem_m [DEPTH];
  logic [31:0] dout_m;

  always #5 Clk = ~Clk;

  sparc_mem_ctrl #(.ADDR_W(AW), .WAIT(2)) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .MOV(MOV), .RW(RW), .Type(Type), .Sign(Sign),
    .Address(Address), .DataIn(DataIn), .DataOut(dout_a), .MOC(moc_a),
    .Align_Err(err_a), .Ld_En(Ld_En), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data)
  );

  sparc_mem_ctrl #(.ADDR_W(AW), .WAIT(3)) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .MOV(MOV), .RW(RW), .Type(Type), .Sign(Sign),
    .Address(Address), .DataIn(DataIn), .DataOut(dout_b), .MOC(moc_b),
    .Align_Err(err_b), .Ld_En(Ld_En), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Reference: n-byte big-endian access, fault on misalignment or reserved type.
  function automatic bit model_access(input bit rw, input bit [1:0] typ, input bit sgn,
                                      input int addr, input logic [31:0] din);
    int n;
    logic [31:0] v;
    n = 1 << typ;
    if (typ == 2'b11 || (addr % n) != 0) return 1'b1;
    if (rw) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_m[addr + i]);
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      dout_m = v;
    end else begin
      for (int i = 0; i < n; i++) mem_m[addr + i] = 8'((din >> (8*(n-1-i))) & 32'hFF);
    end
    return 1'b0;
  endfunction

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge Clk);
    Ld_En = 1'b1; Ld_Addr = AW'(a); Ld_Data = d;
    @(posedge Clk); #1;
    Ld_En = 1'b0;
    mem_m[a] = d;
  endtask

  // ld_mode: 0 none, 1 preload alongside MOV at capture, 2 preload during WAIT.
  task automatic do_access(input bit rw, input bit [1:0] typ, input bit sgn, input int addr,
                           input logic [31:0] din, input int ld_mode, input int la,
                           input logic [7:0] ld);
    bit exp_e;
    exp_e = model_access(rw, typ, sgn, addr, din);
    @(negedge Clk);
    MOV = 1'b1; RW = rw; Type = typ; Sign = sgn; Address = AW'(addr); DataIn = din;
    if (ld_mode == 1) begin Ld_En = 1'b1; Ld_Addr = AW'(la); Ld_Data = ld; end
    @(posedge Clk); #1;
    Ld_En = 1'b0;
    // Everything but MOV is don't-care once captured.
    RW = ~rw; Type = 2'($urandom); Sign = ~sgn; Address = AW'($urandom); DataIn = $urandom;
    if (ld_mode == 2) begin Ld_En = 1'b1; Ld_Addr = AW'(la); Ld_Data = ld; end
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk); #1;
      Ld_En = 1'b0;
      chk("moc_lat_w2", {31'd0, moc_a}, {31'd0, k >= 3});
      chk("moc_lat_w3", {31'd0, moc_b}, {31'd0, k >= 4});
    end
    chk("dout_w2", dout_a, dout_m);
    chk("dout_w3", dout_b, dout_m);
    chk("aerr_w2", {31'd0, err_a}, {31'd0, exp_e});
    chk("aerr_w3", {31'd0, err_b}, {31'd0, exp_e});
    @(posedge Clk); #1;
    chk("moc_hold", {30'd0, moc_a, moc_b}, 32'd3);
    @(negedge Clk);
    MOV = 1'b0;
    @(posedge Clk); #1;
    chk("moc_fall", {30'd0, moc_a, moc_b}, 32'd0);
    chk("dout_keep", dout_a, dout_m);
  endtask

  initial begin
    bit [1:0] typ;
    int       addr, old_addr;
    logic [31:0] rd;

    Rst_n = 1'b0; MOV = 1'b0; RW = 1'b1; Type = 2'b00; Sign = 1'b0;
    Address = '0; DataIn = 32'h0; Ld_En = 1'b0; Ld_Addr = '0; Ld_Data = 8'h00;
    dout_m = 32'h0;
    #12;
    chk("rst_moc",  {30'd0, moc_a, moc_b}, 32'd0);
    chk("rst_dout", dout_a | dout_b, 32'd0);
    chk("rst_aerr", {30'd0, err_a, err_b}, 32'd0);
    #9 Rst_n = 1'b1;

    // Fill the whole array so every later read has defined contents.
    for (int a = 0; a < DEPTH; a++) preload(a, 8'($urandom));

    preload(0, 8'h8A); preload(1, 8'h00); preload(2, 8'h40); preload(3, 8'h01);
    do_access(1'b1, 2'b10, 1'b0, 0, 32'h0, 0, 0, 8'h00);
    chk("word0_const", dout_a, 32'h8A00_4001);
    do_access(1'b1, 2'b00, 1'b0, 0, 32'h0, 0, 0, 8'h00);
    chk("byte0_zx", dout_a, 32'h0000_008A);
    do_access(1'b1, 2'b00, 1'b1, 0, 32'h0, 0, 0, 8'h00);
    chk("byte0_sx", dout_a, 32'hFFFF_FF8A);
    do_access(1'b1, 2'b01, 1'b1, 2, 32'h0, 0, 0, 8'h00);
    chk("half2_sx", dout_a, 32'h0000_4001);

    do_access(1'b0, 2'b01, 1'b0, 6, 32'hDEAD_1234, 0, 0, 8'h00);
    do_access(1'b1, 2'b10, 1'b0, 4, 32'h0, 0, 0, 8'h00);
    chk("half_wr_low", {16'd0, dout_a[15:0]}, 32'h0000_1234);

    // Faulting accesses: memory and DataOut unchanged.
    do_access(1'b1, 2'b10, 1'b0, 2, 32'h0, 0, 0, 8'h00);
    do_access(1'b0, 2'b01, 1'b0, 5, 32'hFFFF_FFFF, 0, 0, 8'h00);
    do_access(1'b1, 2'b11, 1'b0, 8, 32'h0, 0, 0, 8'h00);
    do_access(1'b0, 2'b11, 1'b0, 4, 32'hFFFF_FFFF, 0, 0, 8'h00);
    do_access(1'b1, 2'b10, 1'b0, 4, 32'h0, 0, 0, 8'h00);

    // Preloads colliding with MOV or landing in WAIT are dropped.
    do_access(1'b1, 2'b10, 1'b0, 16, 32'h0, 1, 16, ~mem_m[16]);
    do_access(1'b1, 2'b10, 1'b0, 16, 32'h0, 2, 17, ~mem_m[17]);
    do_access(1'b1, 2'b10, 1'b0, 16, 32'h0, 0, 0, 8'h00);
    preload(16, ~mem_m[16]);
    preload(17, ~mem_m[17]);
    do_access(1'b1, 2'b10, 1'b0, 16, 32'h0, 0, 0, 8'h00);

    // Reset mid-write: pending access discarded, memory untouched.
    old_addr = 40;
    @(negedge Clk);
    MOV = 1'b1; RW = 1'b0; Type = 2'b10; Sign = 1'b0; Address = AW'(old_addr);
    DataIn = ~{mem_m[40], mem_m[41], mem_m[42], mem_m[43]};
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_moc",  {30'd0, moc_a, moc_b}, 32'd0);
    chk("arst_dout", dout_a | dout_b, 32'd0);
    dout_m = 32'h0;
    @(negedge Clk);
    MOV = 1'b0;
    #1 Rst_n = 1'b1;
    do_access(1'b1, 2'b10, 1'b0, old_addr, 32'h0, 0, 0, 8'h00);
    rd = {mem_m[40], mem_m[41], mem_m[42], mem_m[43]};
    chk("arst_mem_kept", dout_b, rd);

    // Random traffic, mostly aligned, with occasional preloads.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        preload(int'($urandom_range(0, DEPTH-1)), 8'($urandom));
      end else begin
        typ  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr = int'($urandom_range(0, DEPTH-1));
        if (typ != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((1 << typ) - 1);
        do_access(1'($urandom), typ, 1'($urandom), addr, $urandom, 0, 0, 8'h00);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
